// File: rtl/laser_packet_assembler.sv
`default_nettype none
// ============================================================================
// laser_packet_assembler: frames LaserReceiver byte pairs into checked packets
// and forwards good START/STOP packets bytewise. Option: LASER_PKT_CHECKSUM_EN
// Revision 1.0
// ============================================================================
module laser_packet_assembler #(
  parameter int BUF_BYTES      = 512,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int START_LEN      = 512,
  parameter int STOP_LEN       = 6,
  parameter int ACK_LEN        = 4,
  parameter int FAIL_LEN       = 4,
  parameter int DONE_LEN       = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] data1_in,
  input  logic [7:0] data2_in,
  output logic [7:0] send_data,
  output logic       send_valid,
  input  logic       send_ready,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic [2:0] pkt_type,
  output logic       overrun,
  output logic       busy
);

  localparam int PAIR_W = $clog2(BUF_BYTES / 2) + 1;
  localparam int RD_W   = $clog2(BUF_BYTES);
  localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] TYPE_START   = 3'd1;
  localparam logic [2:0] TYPE_STOP    = 3'd2;
  localparam logic [2:0] TYPE_ACK     = 3'd3;
  localparam logic [2:0] TYPE_FAIL    = 3'd4;
  localparam logic [2:0] TYPE_DONE    = 3'd5;
  localparam logic [2:0] TYPE_UNKNOWN = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  function automatic logic [2:0] decode_hdr(input logic [7:0] hdr);
    case (hdr)
      8'hcc:   return TYPE_START;
      8'h55:   return TYPE_STOP;
      8'h11:   return TYPE_ACK;
      8'hbb:   return TYPE_FAIL;
      8'haa:   return TYPE_DONE;
      default: return TYPE_UNKNOWN;
    endcase
  endfunction

  function automatic logic [PAIR_W-1:0] len_pairs(input logic [2:0] t);
    case (t)
      TYPE_START: return PAIR_W'(START_LEN / 2);
      TYPE_STOP:  return PAIR_W'(STOP_LEN / 2);
      TYPE_ACK:   return PAIR_W'(ACK_LEN / 2);
      TYPE_FAIL:  return PAIR_W'(FAIL_LEN / 2);
      default:    return PAIR_W'(DONE_LEN / 2);
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        cur_type_q, cur_type_d;
  logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [RD_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic              send_valid_q, send_valid_d;
  logic              pkt_done_q, pkt_done_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic [2:0]        pkt_type_q, pkt_type_d;
  logic              overrun_q, overrun_d;

  logic [7:0]        lane1_mem_q [BUF_BYTES/2];
  logic [7:0]        lane2_mem_q [BUF_BYTES/2];
  logic              wr_en;
  logic [PAIR_W-2:0] wr_idx;
  logic [2:0]        hdr_type;
  logic              first_ok, final_ok, last_byte;

`ifdef LASER_PKT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  // Trailing byte must equal the XOR of every byte before it in the packet.
  assign first_ok = (data2_in == data1_in);
  assign final_ok = (data2_in == (csum_q ^ data1_in));
`else
  assign first_ok = 1'b1;
  assign final_ok = 1'b1;
`endif

  assign hdr_type  = decode_hdr(data1_in);
  assign last_byte = ((PAIR_W+1)'(rd_ptr_q) ==
                      ({len_pairs(cur_type_q), 1'b0} - (PAIR_W+1)'(1)));

  always_comb begin
    state_d      = state_q;
    cur_type_d   = cur_type_q;
    pair_cnt_d   = pair_cnt_q;
    gap_d        = gap_q;
    rd_ptr_d     = rd_ptr_q;
    send_valid_d = send_valid_q;
    pkt_done_d   = 1'b0;
    pkt_ok_d     = pkt_ok_q;
    pkt_type_d   = pkt_type_q;
    overrun_d    = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = pair_cnt_q[PAIR_W-2:0];
`ifdef LASER_PKT_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          if (hdr_type == TYPE_UNKNOWN) begin
            pkt_done_d = 1'b1;
            pkt_ok_d   = 1'b0;
            pkt_type_d = TYPE_UNKNOWN;
          end else begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            cur_type_d = hdr_type;
            pair_cnt_d = PAIR_W'(1);
            gap_d      = '0;
`ifdef LASER_PKT_CHECKSUM_EN
            csum_d     = data1_in ^ data2_in;
`endif
            if (len_pairs(hdr_type) == PAIR_W'(1)) begin
              state_d    = ST_CHECK;
              pkt_done_d = 1'b1;
              pkt_ok_d   = first_ok;
              pkt_type_d = hdr_type;
            end else begin
              state_d = ST_COLLECT;
            end
          end
        end
      end
      ST_COLLECT: begin
        // An expired gap takes priority over a pair arriving the same cycle.
        if (gap_q == GAP_W'(TIMEOUT_CYCLES)) begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
          pkt_ok_d   = 1'b0;
          pkt_type_d = cur_type_q;
        end else if (data_valid) begin
          wr_en      = 1'b1;
          pair_cnt_d = pair_cnt_q + PAIR_W'(1);
          gap_d      = '0;
`ifdef LASER_PKT_CHECKSUM_EN
          csum_d     = csum_q ^ data1_in ^ data2_in;
`endif
          if (pair_cnt_d == len_pairs(cur_type_q)) begin
            state_d    = ST_CHECK;
            pkt_done_d = 1'b1;
            pkt_ok_d   = final_ok;
            pkt_type_d = cur_type_q;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_CHECK: begin
        overrun_d = data_valid;
        if (pkt_ok_q && (cur_type_q == TYPE_START || cur_type_q == TYPE_STOP)) begin
          state_d      = ST_DRAIN;
          send_valid_d = 1'b1;
          rd_ptr_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        overrun_d = data_valid;
        if (send_valid_q && send_ready) begin
          if (last_byte) begin
            state_d      = ST_IDLE;
            send_valid_d = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + RD_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_type_q   <= 3'd0;
      pair_cnt_q   <= '0;
      gap_q        <= '0;
      rd_ptr_q     <= '0;
      send_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_type_q   <= 3'd0;
      overrun_q    <= 1'b0;
`ifdef LASER_PKT_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      cur_type_q   <= cur_type_d;
      pair_cnt_q   <= pair_cnt_d;
      gap_q        <= gap_d;
      rd_ptr_q     <= rd_ptr_d;
      send_valid_q <= send_valid_d;
      pkt_done_q   <= pkt_done_d;
      pkt_ok_q     <= pkt_ok_d;
      pkt_type_q   <= pkt_type_d;
      overrun_q    <= overrun_d;
`ifdef LASER_PKT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      lane1_mem_q[wr_idx] <= data1_in;
      lane2_mem_q[wr_idx] <= data2_in;
    end
  end

  assign send_data  = rd_ptr_q[0] ? lane2_mem_q[rd_ptr_q[RD_W-1:1]]
                                  : lane1_mem_q[rd_ptr_q[RD_W-1:1]];
  assign send_valid = send_valid_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_type   = pkt_type_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_laser_packet_assembler.sv
`default_nettype none
// ============================================================================
// tb_laser_packet_assembler: directed vector table plus corner-case sequences
// for laser_packet_assembler. Honours LASER_PKT_CHECKSUM_EN.
// Revision 1.0
// ============================================================================
module tb_laser_packet_assembler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data1_in = 8'h00;
  logic [7:0] data2_in = 8'h00;
  logic       send_ready = 1'b0;
  logic [7:0] send_data;
  logic       send_valid;
  logic       pkt_done;
  logic       pkt_ok;
  logic [2:0] pkt_type;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // STOP trailer that makes the packet good in either build.
`ifdef LASER_PKT_CHECKSUM_EN
  localparam logic [7:0] STOP_LAST = 8'h51;
`else
  localparam logic [7:0] STOP_LAST = 8'h05;
`endif

  laser_packet_assembler dut (
    .clock      (clock),
    .reset      (reset),
    .data_valid (data_valid),
    .data1_in   (data1_in),
    .data2_in   (data2_in),
    .send_data  (send_data),
    .send_valid (send_valid),
    .send_ready (send_ready),
    .pkt_done   (pkt_done),
    .pkt_ok     (pkt_ok),
    .pkt_type   (pkt_type),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       rdy;
    logic       done;
    logic       ok;
    logic [2:0] typ;
    logic       sv;
    logic [7:0] sd;
    logic       bsy;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic dv, input logic [7:0] d1,
                              input logic [7:0] d2, input logic rdy, input logic done,
                              input logic ok, input logic [2:0] typ, input logic sv,
                              input logic [7:0] sd, input logic bsy, input logic ovr);
    vec_t v;
    v.rst = rst; v.dv = dv; v.d1 = d1; v.d2 = d2; v.rdy = rdy;
    v.done = done; v.ok = ok; v.typ = typ; v.sv = sv; v.sd = sd; v.bsy = bsy; v.ovr = ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] d1, input logic [7:0] d2,
                      input logic rdy);
    data_valid = dv;
    data1_in   = d1;
    data2_in   = d2;
    send_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  logic [7:0] exp_bytes[6];
  logic [7:0] got_bytes[$];
  int         ovr_cnt;
  int         early;
  logic       busy_bad;
  logic       sv_seen;

  initial begin
    exp_bytes[0] = 8'h55; exp_bytes[1] = 8'h01; exp_bytes[2] = 8'h02;
    exp_bytes[3] = 8'h03; exp_bytes[4] = 8'h04; exp_bytes[5] = STOP_LAST;

    // reset, STOP packet with ready held high, then an ACK packet
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h55, 8'h01, 1, 0, 0, 3'd0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 8'h02, 8'h03, 1, 0, 0, 3'd0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 8'h04, STOP_LAST, 1, 1, 1, 3'd2, 0, 8'h00, 1, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 3'd2, 1, exp_bytes[i], 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 3'd2, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 8'h00, 1, 0, 1, 3'd2, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h11, 1, 1, 1, 3'd3, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 3'd3, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 3'd3, 0, 8'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      step(tbl[i].dv, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
      check($sformatf("row%0d pkt_done", i), 32'(pkt_done), 32'(tbl[i].done));
      check($sformatf("row%0d pkt_ok", i), 32'(pkt_ok), 32'(tbl[i].ok));
      check($sformatf("row%0d pkt_type", i), 32'(pkt_type), 32'(tbl[i].typ));
      check($sformatf("row%0d send_valid", i), 32'(send_valid), 32'(tbl[i].sv));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("row%0d overrun", i), 32'(overrun), 32'(tbl[i].ovr));
      if (tbl[i].sv)
        check($sformatf("row%0d send_data", i), 32'(send_data), 32'(tbl[i].sd));
    end
    reset = 1'b0;

    // unknown header, then a one-pair DONE packet
    step(1, 8'h7e, 8'h00, 1);
    check("unknown done", 32'(pkt_done), 32'd1);
    check("unknown ok", 32'(pkt_ok), 32'd0);
    check("unknown type", 32'(pkt_type), 32'd7);
    check("unknown busy", 32'(busy), 32'd0);
    step(1, 8'haa, 8'haa, 1);
    check("done_pkt done", 32'(pkt_done), 32'd1);
    check("done_pkt ok", 32'(pkt_ok), 32'd1);
    check("done_pkt type", 32'(pkt_type), 32'd5);
    step(0, 8'h00, 8'h00, 1);
    check("done_pkt no drain", 32'(send_valid), 32'd0);
    check("done_pkt idle", 32'(busy), 32'd0);

    // START timeout: 10 pairs then silence; the pair on the timeout cycle is dropped
    sv_seen = 1'b0;
    early   = 0;
    step(1, 8'hcc, 8'h00, 1);
    for (int i = 1; i < 10; i++) step(1, 8'(i), 8'(i), 1);
    for (int i = 1; i <= 256; i++) begin
      if (i < 256) step(0, 8'h00, 8'h00, 1);
      else         step(1, 8'haa, 8'haa, 1);
      if (send_valid) sv_seen = 1'b1;
      if (i < 256 && pkt_done) early++;
    end
    check("timeout early done", 32'(early), 32'd0);
    check("timeout done", 32'(pkt_done), 32'd1);
    check("timeout ok", 32'(pkt_ok), 32'd0);
    check("timeout type", 32'(pkt_type), 32'd1);
    check("timeout busy", 32'(busy), 32'd0);
    step(0, 8'h00, 8'h00, 1);
    check("timeout pair not decoded", 32'(pkt_done), 32'd0);
    check("timeout no send_valid", 32'(sv_seen), 32'd0);

    // STOP drain with ready toggling and a pair arriving mid-drain
    step(1, 8'h55, 8'h01, 0);
    step(1, 8'h02, 8'h03, 0);
    step(1, 8'h04, STOP_LAST, 0);
    check("toggle check done", 32'(pkt_done), 32'd1);
    step(0, 8'h00, 8'h00, 0);
    check("toggle drain start", 32'(send_valid), 32'd1);
    ovr_cnt  = 0;
    busy_bad = 1'b0;
    got_bytes.delete();
    for (int c = 0; c < 40 && got_bytes.size() < 6; c++) begin
      send_ready = (c % 2 == 0);
      data_valid = (c == 3);
      if (send_valid && send_ready) got_bytes.push_back(send_data);
      step(data_valid, 8'hcc, 8'h00, send_ready);
      if (overrun) ovr_cnt++;
      if (got_bytes.size() < 6 && !busy) busy_bad = 1'b1;
    end
    check("toggle byte count", 32'(got_bytes.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_bytes.size(); i++)
      check($sformatf("toggle byte%0d", i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    check("toggle busy held", 32'(busy_bad), 32'd0);
    check("toggle end send_valid", 32'(send_valid), 32'd0);
    check("toggle end busy", 32'(busy), 32'd0);
    step(0, 8'h00, 8'h00, 1);
    if (overrun) ovr_cnt++;
    check("toggle overrun count", 32'(ovr_cnt), 32'd1);
    check("toggle pair ignored", 32'(busy), 32'd0);

    // reset in the middle of a packet discards it
    step(1, 8'h55, 8'h01, 1);
    reset = 1'b1;
    step(0, 8'h00, 8'h00, 1);
    reset = 1'b0;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset type", 32'(pkt_type), 32'd0);
    check("midreset ok", 32'(pkt_ok), 32'd0);
    step(1, 8'h02, 8'h03, 1);
    check("midreset stale pair", 32'(busy), 32'd0);

`ifdef LASER_PKT_CHECKSUM_EN
    // bad trailer: 55^01^02^03^04 = 51, so 50 must be rejected
    sv_seen = 1'b0;
    step(1, 8'h55, 8'h01, 1);
    step(1, 8'h02, 8'h03, 1);
    step(1, 8'h04, 8'h50, 1);
    check("csum bad done", 32'(pkt_done), 32'd1);
    check("csum bad ok", 32'(pkt_ok), 32'd0);
    check("csum bad type", 32'(pkt_type), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 8'h00, 1);
      if (send_valid) sv_seen = 1'b1;
    end
    check("csum bad no drain", 32'(sv_seen), 32'd0);
    check("csum bad idle", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
